prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 21 ++
 rtl/word_packer.sv | 44 ++++
 rtl/prog_loader.sv | 114 +++++++++++
 tb/tb_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants, state encoding and header check for the program loader
package loader_pkg;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // A header is usable when it asks for at least one word and no more than fit in imem.
    function automatic logic hdr_valid(input logic [15:0] n);
        return (n != 16'd0) && (n <= 16'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - assembles four little-endian bytes into a 32-bit word
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_clear       restart lane counting at byte 0 (start of a new program)
//   i_load        a byte is accepted this cycle
//   i_data        the accepted byte
//   o_word        assembled word register
//   o_word_full   the byte accepted this cycle completes the word (lane 3)
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_byte_idx <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
        end else if (i_load) begin
            case (r_byte_idx)
                2'd0:    r_word[7:0]   <= i_data;
                2'd1:    r_word[15:8]  <= i_data;
                2'd2:    r_word[23:16] <= i_data;
                default: r_word[31:24] <= i_data;
            endcase
            // 2-bit counter wraps 3 -> 0 so the next word starts at lane 0
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_load && (r_byte_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a counted program into instruction memory, then releases the CPU
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready byte stream from the host link
//   restart                   reload request, honoured only in RUN or ERR
//   imem_we/addr/wdata        one-cycle word write into instruction memory
//   cpu_rst                   holds the processor in reset until a program is loaded
//   done                      program loaded, processor running
//   err                       invalid word count received
module prog_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic              r_active;
    logic [7:0]        r_count_lo;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;

    logic              w_accept;
    logic [15:0]       w_hdr;
    logic              w_hdr_ok;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic              w_word_full;

    // in_ready stays low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_active <= 1'b0;
        else      r_active <= 1'b1;
    end

    assign in_ready = r_active &&
                      ((r_state == ST_HDR0) || (r_state == ST_HDR1) || (r_state == ST_LOAD));
    assign w_accept    = in_valid && in_ready;
    assign w_hdr       = {in_data, r_count_lo};
    assign w_hdr_ok    = hdr_valid(w_hdr);
    assign w_last_word = (r_addr == r_last);

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept && (r_state == ST_HDR1)),
        .i_load      (w_accept && (r_state == ST_LOAD)),
        .i_data      (in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_HDR0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR0:  if (w_accept) w_next = ST_HDR1;
            ST_HDR1:  if (w_accept) w_next = w_hdr_ok ? ST_LOAD : ST_ERR;
            ST_LOAD:  if (w_word_full) w_next = ST_WRITE;
            ST_WRITE: w_next = w_last_word ? ST_RUN : ST_LOAD;
            ST_RUN:   if (restart) w_next = ST_HDR0;
            ST_ERR:   if (restart) w_next = ST_HDR0;
            default:  w_next = ST_HDR0;
        endcase
    end

    // Header capture and word addressing. r_last holds N-1 so the
    // end-of-program test is a plain compare against the current address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_lo <= '0;
            r_addr     <= '0;
            r_last     <= '0;
        end else begin
            if ((r_state == ST_HDR0) && w_accept) begin
                r_count_lo <= in_data;
            end
            if ((r_state == ST_HDR1) && w_accept) begin
                r_addr <= '0;
                if (w_hdr_ok) r_last <= ADDR_W'(w_hdr - 16'd1);
            end
            if ((r_state == ST_WRITE) && !w_last_word) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign imem_we    = (r_state == ST_WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign done       = (r_state == ST_RUN);
    assign cpu_rst    = (r_state != ST_RUN);
    assign err        = (r_state == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        restart = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int last_we_cyc = -1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && imem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wdata), 64'(e.data));
                check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
                check("wr_in_ready_low", 64'(in_ready), 64'd0);
            end
        end
    end

    // Entered and left just after a rising edge. acc_cyc is the cycle in
    // which the loader's response to this byte becomes visible.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int  n;
        logic rdy;
        int  c;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        c = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            c   = cyc;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
        acc_cyc  = c + 1;
    endtask

    function automatic int pick_gap(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 2)) : mode;
    endfunction

    // Model: word i of the stream lands at address i, one cycle after its
    // fourth byte is accepted.
    task automatic load_stream(input logic [31:0] words[$], input int mode, input bit poke_restart);
        int acc;
        int n;
        logic [31:0] w;
        wr_t e;
        n = words.size();
        send_byte(8'(n), pick_gap(mode), acc);
        send_byte(8'(n >> 8), pick_gap(mode), acc);
        if (poke_restart) begin
            restart = 1'b1;
            @(posedge clk); #1;
            restart = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[k*8 +: 8], pick_gap(mode), acc);
            end
            e.addr = i;
            e.data = w;
            e.cyc  = acc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_run_cycle"}, 64'(cyc), 64'(last_we_cyc + 1));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic bad_header(input logic [15:0] n, input string tag);
        int acc;
        send_byte(n[7:0], 0, acc);
        send_byte(n[15:8], 0, acc);
        check({tag, "_err"}, 64'(err), 64'd1);
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_err_held"}, 64'(err), 64'd1);
        pulse_restart();
        check({tag, "_restart_err"}, 64'(err), 64'd0);
        check({tag, "_restart_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_restart_cpu_rst"}, 64'(cpu_rst), 64'd1);
    endtask

    initial begin
        logic [31:0] ws[$];
        int acc;

        // Reset state
        #12;
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #5 rst = 1'b1;                      // t=17, between edges
        @(negedge clk);
        check("rst_release_no_edge_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rst_release_first_edge_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single instruction 0x00000013
        ws = '{32'h0000_0013};
        load_stream(ws, 0, 1'b0);
        wait_run("one_word");

        // Restart from RUN and reload 0xDEADBEEF
        pulse_restart();
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        check("reload_in_ready", 64'(in_ready), 64'd1);
        ws = '{32'hDEAD_BEEF};
        load_stream(ws, 0, 1'b0);
        wait_run("reload");
        pulse_restart();

        // Three words with in_valid toggling every other cycle
        ws = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        load_stream(ws, 1, 1'b0);
        wait_run("three_words");
        pulse_restart();

        // Invalid headers
        bad_header(16'd0, "hdr_zero");
        bad_header(16'd1025, "hdr_1025");

        // Randomised loads; some with a restart pulse mid-load that must be ignored
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 8);
            ws.delete();
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            load_stream(ws, -1, t[0]);
            wait_run("random");
            pulse_restart();
        end

        // Reset after two bytes of word 1 of a two-word program
        send_byte(8'd2, 0, acc);
        send_byte(8'd0, 0, acc);
        ws = '{32'hA5A5_0001};
        for (int k = 0; k < 4; k++) send_byte(ws[0][k*8 +: 8], 0, acc);
        begin
            wr_t e;
            e.addr = 0;
            e.data = 32'hA5A5_0001;
            e.cyc  = acc;
            exp_q.push_back(e);
        end
        send_byte(8'h77, 0, acc);
        send_byte(8'h66, 0, acc);
        rst = 1'b0;
        #1;
        check("midrst_imem_we", 64'(imem_we), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("midrst_first_word_written", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready_after", 64'(in_ready), 64'd1);
        check("midrst_done_after", 64'(done), 64'd0);
        ws = '{32'hCAFE_0000, 32'hCAFE_0001};
        load_stream(ws, -1, 1'b0);
        wait_run("after_midrst");
        pulse_restart();

        // Full 1024-word program with incrementing data
        ws.delete();
        for (int i = 0; i < 1024; i++) ws.push_back(32'(i));
        load_stream(ws, 0, 1'b0);
        wait_run("full_1024");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
